// File: rtl/uart_pkt_ctrl.sv
// Purpose: frames UART receiver bytes into SYNC/CMD/ADDR/DATA/CHK packets; issues register writes or baud changes.
// Latency: results registered 2 clk edges after the checksum byte strobe; timeout fires TIMEOUT edges after the last strobe.
// Backpressure: none; bytes arriving during the one-cycle EXEC state are dropped, stalled packets are aborted by timeout.
module uart_pkt_ctrl #(
  parameter int          TIMEOUT      = 200000,
  parameter logic [1:0]  BAUD_DEFAULT = 2'b00,
  parameter logic [7:0]  SYNC         = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       data_valid,
  output logic [1:0] brate_sel,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic [7:0] pkt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC
  } state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        dv_q;
  logic        stb;
  logic [19:0] tmo_cnt;
  logic        tmo_fire;
  logic [7:0]  cmd_q, addr_q, data_q, chk_q;
  logic        do_wr, do_baud, err_chk, err_arg;

  // dv_q resets high so a data_valid level already present at reset is not seen as a new byte
  always_ff @(posedge clk) begin
    if (rst) dv_q <= 1'b1;
    else     dv_q <= data_valid;
  end

  assign stb = data_valid & ~dv_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and EXEC decode; a strobe always beats the timeout terminal count
  always_comb begin
    state_nxt = state;
    tmo_fire  = 1'b0;
    do_wr     = 1'b0;
    do_baud   = 1'b0;
    err_chk   = 1'b0;
    err_arg   = 1'b0;
    unique case (state)
      S_IDLE: if (stb && byte_data == SYNC) state_nxt = S_CMD;
      S_CMD, S_ADDR, S_DATA, S_CHK: begin
        if (stb) begin
          unique case (state)
            S_CMD:   state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_DATA;
            S_DATA:  state_nxt = S_CHK;
            default: state_nxt = S_EXEC;
          endcase
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = S_IDLE;
          tmo_fire  = 1'b1;
        end
      end
      S_EXEC: begin
        state_nxt = S_IDLE;
        if ((cmd_q ^ addr_q ^ data_q) != chk_q)
          err_chk = 1'b1;
        else if (cmd_q == 8'h01)
          do_wr = 1'b1;
        else if (cmd_q == 8'h02 && data_q[7:2] == 6'd0 && data_q[1:0] != 2'b11)
          do_baud = 1'b1;
        else
          err_arg = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Inter-byte timeout counter: runs only while a packet is partially received
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (stb || tmo_fire || state == S_IDLE || state == S_EXEC)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 20'd1;
  end

  // Capture packet fields as their strobes arrive
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      chk_q  <= '0;
    end else if (stb) begin
      if (state == S_CMD)  cmd_q  <= byte_data;
      if (state == S_ADDR) addr_q <= byte_data;
      if (state == S_DATA) data_q <= byte_data;
      if (state == S_CHK)  chk_q  <= byte_data;
    end
  end

  // Registered outputs: single-cycle pulses, held address/data/baud/error code, packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      brate_sel <= BAUD_DEFAULT;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
      pkt_cnt   <= '0;
    end else begin
      wr_en   <= do_wr;
      pkt_ok  <= do_wr | do_baud;
      pkt_err <= err_chk | err_arg | tmo_fire;
      if (do_wr) begin
        wr_addr <= addr_q;
        wr_data <= data_q;
      end
      if (do_baud) brate_sel <= data_q[1:0];
      if (err_chk)       err_code <= 2'd1;
      else if (err_arg)  err_code <= 2'd2;
      else if (tmo_fire) err_code <= 2'd3;
      if (do_wr || do_baud) pkt_cnt <= pkt_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Bench for uart_pkt_ctrl: table of known packets, hand-written corner sequences, and random packets
// checked against a packet-level reference model. Uses a short TIMEOUT to keep runs brief.
module tb_uart_pkt_ctrl;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_data;
  logic       data_valid;
  logic [1:0] brate_sel;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [7:0] pkt_cnt;

  uart_pkt_ctrl #(.TIMEOUT(TMO), .BAUD_DEFAULT(2'b00), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .data_valid(data_valid),
    .brate_sel(brate_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_seen = 0, ok_seen = 0, err_seen = 0;

  // reference model state
  logic [7:0] m_cnt;
  logic [1:0] m_brate;
  logic [1:0] m_code;

  typedef struct {
    logic [31:0] body;   // CMD, ADDR, DATA, CHK
    logic        e_wr, e_ok, e_err;
    logic [1:0]  e_code;
    logic [7:0]  e_addr, e_data;
    logic [1:0]  e_brate;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // pulse monitor sampled one time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (rst === 1'b0) begin
      if (wr_en)   wr_seen++;
      if (pkt_ok)  ok_seen++;
      if (pkt_err) err_seen++;
      if (wr_en || pkt_ok || pkt_err)
        chk("pulse_exclusive", {30'd0, pkt_err & (wr_en | pkt_ok)}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    byte_data  = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] k, input int gap);
    send_byte(8'hA5, gap);
    send_byte(c, gap);
    send_byte(a, gap);
    send_byte(d, gap);
    send_byte(k, 0);
  endtask

  // called right after the checksum byte; results must show on the second edge after its strobe
  task automatic check_exp(input string tag, input logic e_wr, input logic e_ok, input logic e_err,
                           input logic [1:0] e_code, input logic [7:0] e_addr, input logic [7:0] e_data,
                           input logic [1:0] e_brate, input logic [7:0] e_cnt);
    chk({tag, ".early"}, {29'd0, wr_en, pkt_ok, pkt_err}, 32'd0);
    @(negedge clk);
    chk({tag, ".wr_en"},    {31'd0, wr_en},   {31'd0, e_wr});
    chk({tag, ".pkt_ok"},   {31'd0, pkt_ok},  {31'd0, e_ok});
    chk({tag, ".pkt_err"},  {31'd0, pkt_err}, {31'd0, e_err});
    chk({tag, ".err_code"}, {30'd0, err_code}, {30'd0, e_code});
    chk({tag, ".brate"},    {30'd0, brate_sel}, {30'd0, e_brate});
    chk({tag, ".pkt_cnt"},  {24'd0, pkt_cnt}, {24'd0, e_cnt});
    if (e_wr) begin
      chk({tag, ".wr_addr"}, {24'd0, wr_addr}, {24'd0, e_addr});
      chk({tag, ".wr_data"}, {24'd0, wr_data}, {24'd0, e_data});
    end
    @(negedge clk);
    chk({tag, ".after"}, {29'd0, wr_en, pkt_ok, pkt_err}, 32'd0);
  endtask

  // packet outcome from the packet rules: 0 write, 1 baud change, 2 checksum error, 3 cmd/arg error
  function automatic int predict(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                                 input logic [7:0] k);
    if ((c ^ a ^ d) != k) return 2;
    if (c == 8'h01) return 0;
    if (c == 8'h02 && d < 8'd3) return 1;
    return 3;
  endfunction

  task automatic model_pkt(input string tag, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] k);
    int kind;
    kind = predict(c, a, d, k);
    if (kind <= 1) m_cnt = m_cnt + 8'd1;
    if (kind == 1) m_brate = d[1:0];
    if (kind == 2) m_code = 2'd1;
    if (kind == 3) m_code = 2'd2;
    check_exp(tag, kind == 0, kind <= 1, kind >= 2, m_code, a, d, m_brate, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 8'd0; m_brate = 2'd0; m_code = 2'd0;
  endtask

  initial begin
    int w0, o0, e0, first;
    logic [7:0] c, a, d, k, j;
    int gap;

    tbl[0] = '{32'h01_10_3C_2D, 1, 1, 0, 2'd0, 8'h10, 8'h3C, 2'd0};
    tbl[1] = '{32'h02_00_01_03, 0, 1, 0, 2'd0, 8'h00, 8'h00, 2'd1};
    tbl[2] = '{32'h02_00_03_01, 0, 0, 1, 2'd2, 8'h00, 8'h00, 2'd1};
    tbl[3] = '{32'h01_10_3C_00, 0, 0, 1, 2'd1, 8'h00, 8'h00, 2'd1};
    tbl[4] = '{32'h02_55_02_55, 0, 1, 0, 2'd1, 8'h00, 8'h00, 2'd2};
    tbl[5] = '{32'h02_00_06_04, 0, 0, 1, 2'd2, 8'h00, 8'h00, 2'd2};
    tbl[6] = '{32'h07_00_00_07, 0, 0, 1, 2'd2, 8'h00, 8'h00, 2'd2};
    tbl[7] = '{32'h07_00_00_00, 0, 0, 1, 2'd1, 8'h00, 8'h00, 2'd2};
    tbl[8] = '{32'h02_00_00_02, 0, 1, 0, 2'd1, 8'h00, 8'h00, 2'd0};
    tbl[9] = '{32'h01_FF_00_FE, 1, 1, 0, 2'd1, 8'hFF, 8'h00, 2'd0};

    // reset with data_valid already high carrying a SYNC byte
    rst = 1'b1; data_valid = 1'b1; byte_data = 8'hA5;
    m_cnt = 8'd0; m_brate = 2'd0; m_code = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst.brate",    {30'd0, brate_sel}, 32'd0);
    chk("rst.pulses",   {29'd0, wr_en, pkt_ok, pkt_err}, 32'd0);
    chk("rst.wr_addr",  {24'd0, wr_addr}, 32'd0);
    chk("rst.wr_data",  {24'd0, wr_data}, 32'd0);
    chk("rst.err_code", {30'd0, err_code}, 32'd0);
    chk("rst.pkt_cnt",  {24'd0, pkt_cnt}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    data_valid = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h3C, 0); send_byte(8'h2D, 0);
    repeat (5) @(negedge clk);
    chk("held_dv.writes", wr_seen + ok_seen + err_seen, 32'd0);

    // known packets
    for (int i = 0; i < 10; i++) begin
      send_pkt(tbl[i].body[31:24], tbl[i].body[23:16], tbl[i].body[15:8], tbl[i].body[7:0], i % 3);
      if (tbl[i].e_ok) m_cnt = m_cnt + 8'd1;
      check_exp($sformatf("tbl%0d", i), tbl[i].e_wr, tbl[i].e_ok, tbl[i].e_err, tbl[i].e_code,
                tbl[i].e_addr, tbl[i].e_data, tbl[i].e_brate, m_cnt);
    end
    m_brate = 2'd0; m_code = 2'd1;

    // leading garbage before SYNC is ignored
    w0 = wr_seen;
    send_byte(8'h00, 0); send_byte(8'hFF, 1);
    send_pkt(8'h01, 8'h10, 8'h3C, 8'h2D, 0);
    model_pkt("junk", 8'h01, 8'h10, 8'h3C, 8'h2D);
    chk("junk.one_write", wr_seen - w0, 32'd1);

    // timeout exactly TMO edges after the last strobe
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    first = -1;
    for (int n = 1; n <= TMO + 10; n++) begin
      @(negedge clk);
      if (pkt_err && first < 0) first = n;
    end
    chk("tmo.latency", first, TMO);
    chk("tmo.err_code", {30'd0, err_code}, 32'd3);
    m_code = 2'd3;
    send_pkt(8'h01, 8'h22, 8'h33, 8'h01 ^ 8'h22 ^ 8'h33, 0);
    model_pkt("tmo.next", 8'h01, 8'h22, 8'h33, 8'h01 ^ 8'h22 ^ 8'h33);

    // strobe on the terminal-count cycle wins over the timeout
    e0 = err_seen;
    send_byte(8'hA5, 0);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h01, 0); send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h01 ^ 8'h44 ^ 8'h55, 0);
    model_pkt("tc_race", 8'h01, 8'h44, 8'h55, 8'h01 ^ 8'h44 ^ 8'h55);
    chk("tc_race.no_err", err_seen - e0, 32'd0);

    // reset mid-packet abandons it and discards an earlier baud change
    send_pkt(8'h02, 8'h00, 8'h02, 8'h00, 0);
    model_pkt("baud2", 8'h02, 8'h00, 8'h02, 8'h00);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0);
    do_reset();
    chk("midrst.brate",    {30'd0, brate_sel}, 32'd0);
    chk("midrst.pkt_cnt",  {24'd0, pkt_cnt}, 32'd0);
    chk("midrst.err_code", {30'd0, err_code}, 32'd0);
    w0 = wr_seen; o0 = ok_seen; e0 = err_seen;
    send_byte(8'h3C, 0); send_byte(8'h2D, 0);
    repeat (4) @(negedge clk);
    chk("midrst.no_pulse", (wr_seen - w0) + (ok_seen - o0) + (err_seen - e0), 32'd0);

    // random packets against the model
    for (int i = 0; i < 150; i++) begin
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, 0);
      end
      case ($urandom_range(0, 3))
        0, 1:    c = 8'h01;
        2:       c = 8'h02;
        default: c = 8'($urandom);
      endcase
      a = 8'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      gap = $urandom_range(0, 3);
      send_pkt(c, a, d, k, gap);
      model_pkt($sformatf("rnd%0d", i), c, a, d, k);
    end

    // packet counter wraps after 256 accepted packets
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      send_pkt(8'h01, a, d, 8'h01 ^ a ^ d, 0);
      model_pkt($sformatf("wrap%0d", i), 8'h01, a, d, 8'h01 ^ a ^ d);
    end
    chk("wrap.zero", {24'd0, pkt_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
